// File: rtl/qosc_pkg.sv
`default_nettype none
// ============================================================================
// qosc_pkg : register map, command bits, reset defaults and sequencer states
// Revision  : 1.0
// ============================================================================
package qosc_pkg;

  localparam logic [2:0] ADDR_RE  = 3'd0;
  localparam logic [2:0] ADDR_IM  = 3'd1;
  localparam logic [2:0] ADDR_PWR = 3'd2;
  localparam logic [2:0] ADDR_ARE = 3'd3;
  localparam logic [2:0] ADDR_AIM = 3'd4;
  localparam logic [2:0] ADDR_BLO = 3'd5;
  localparam logic [2:0] ADDR_BHI = 3'd6;
  localparam logic [2:0] ADDR_CMD = 3'd7;

  localparam int CMD_START_BIT = 0;
  localparam int CMD_STOP_BIT  = 1;

  localparam logic [7:0] RST_RE  = 8'h7D;
  localparam logic [7:0] RST_IM  = 8'h1B;
  localparam logic [7:0] RST_PWR = 8'h40;
  localparam logic [7:0] RST_ARE = 8'h20;
  localparam logic [7:0] RST_AIM = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/qosc_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// qosc_seq_ctrl_if : host write channel (valid/ready, address, data)
// Revision         : 1.0
// ============================================================================
interface qosc_seq_ctrl_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface
`default_nettype wire

// File: rtl/qosc_regfile.sv
`default_nettype none
// ============================================================================
// qosc_regfile : shadow/active register bank with write handshake and START copy
// Revision     : 1.0
// ============================================================================
module qosc_regfile
  import qosc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  qosc_seq_ctrl_if.slave        host,
  input  wire logic             i_ready,
  output logic                  o_start,
  output logic                  o_stop,
  output logic [7:0]            o_re,
  output logic [7:0]            o_im,
  output logic [7:0]            o_pwr,
  output logic [7:0]            o_are,
  output logic [7:0]            o_aim,
  output logic [CNT_W-1:0]      o_burst
);

  logic             w_acc;
  logic             w_cmd;
  logic [7:0]       r_sh_re, r_sh_im, r_sh_pwr, r_sh_are, r_sh_aim;
  logic [15:0]      r_sh_burst;
  logic [7:0]       r_act_re, r_act_im, r_act_pwr, r_act_are, r_act_aim;
  logic [CNT_W-1:0] r_act_burst;

  assign host.wr_ready = i_ready;
  assign w_acc   = host.wr_valid & i_ready;
  assign w_cmd   = w_acc & (host.wr_addr == ADDR_CMD);
  // STOP dominates a simultaneous START
  assign o_stop  = w_cmd & host.wr_data[CMD_STOP_BIT];
  assign o_start = w_cmd & host.wr_data[CMD_START_BIT] & ~host.wr_data[CMD_STOP_BIT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_re     <= RST_RE;
      r_sh_im     <= RST_IM;
      r_sh_pwr    <= RST_PWR;
      r_sh_are    <= RST_ARE;
      r_sh_aim    <= RST_AIM;
      r_sh_burst  <= '0;
      r_act_re    <= RST_RE;
      r_act_im    <= RST_IM;
      r_act_pwr   <= RST_PWR;
      r_act_are   <= RST_ARE;
      r_act_aim   <= RST_AIM;
      r_act_burst <= '0;
    end else begin
      if (w_acc) begin
        case (host.wr_addr)
          ADDR_RE:  r_sh_re           <= host.wr_data;
          ADDR_IM:  r_sh_im           <= host.wr_data;
          ADDR_PWR: r_sh_pwr          <= host.wr_data;
          ADDR_ARE: r_sh_are          <= host.wr_data;
          ADDR_AIM: r_sh_aim          <= host.wr_data;
          ADDR_BLO: r_sh_burst[7:0]   <= host.wr_data;
          ADDR_BHI: r_sh_burst[15:8]  <= host.wr_data;
          default:  ;
        endcase
      end
      if (o_start) begin
        r_act_re    <= r_sh_re;
        r_act_im    <= r_sh_im;
        r_act_pwr   <= r_sh_pwr;
        r_act_are   <= r_sh_are;
        r_act_aim   <= r_sh_aim;
        r_act_burst <= r_sh_burst[CNT_W-1:0];
      end
    end
  end

  assign o_re    = r_act_re;
  assign o_im    = r_act_im;
  assign o_pwr   = r_act_pwr;
  assign o_are   = r_act_are;
  assign o_aim   = r_act_aim;
  assign o_burst = r_act_burst;

endmodule
`default_nettype wire

// File: rtl/qosc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// qosc_seq_ctrl : IDLE -> LOAD -> RUN sequencer driving the oscillator load
// Revision      : 1.0
// ============================================================================
module qosc_seq_ctrl
  import qosc_pkg::*;
#(
  parameter int LOAD_EDGES = 2,
  parameter int CNT_W      = 16
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         takt,
  qosc_seq_ctrl_if.slave    host,
  output logic              osc_load,
  output logic [7:0]        re_coeff,
  output logic [7:0]        im_coeff,
  output logic [7:0]        power,
  output logic [7:0]        accu_re_init,
  output logic [7:0]        accu_im_init,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  edge_cnt
);

  localparam int LW = $clog2(LOAD_EDGES + 1);

  state_t           r_state;
  logic             r_takt_q;
  logic             r_osc_load;
  logic             r_busy;
  logic             r_done;
  logic             r_wr_ready;
  logic [CNT_W-1:0] r_edge_cnt;
  logic [LW-1:0]    r_load_cnt;

  logic             w_takt_rise;
  logic             w_start;
  logic             w_stop;
  logic [CNT_W-1:0] w_burst;
  logic [CNT_W-1:0] w_cnt_nxt;

  qosc_regfile #(.CNT_W(CNT_W)) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .host    (host),
    .i_ready (r_wr_ready),
    .o_start (w_start),
    .o_stop  (w_stop),
    .o_re    (re_coeff),
    .o_im    (im_coeff),
    .o_pwr   (power),
    .o_are   (accu_re_init),
    .o_aim   (accu_im_init),
    .o_burst (w_burst)
  );

  assign w_takt_rise = takt & ~r_takt_q;
  assign w_cnt_nxt   = r_edge_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_takt_q   <= 1'b0;
      r_osc_load <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wr_ready <= 1'b1;
      r_edge_cnt <= '0;
      r_load_cnt <= '0;
    end else begin
      r_takt_q <= takt;
      r_done   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state    <= LOAD;
            r_edge_cnt <= '0;
            r_load_cnt <= '0;
            r_osc_load <= 1'b1;
            r_busy     <= 1'b1;
            r_wr_ready <= 1'b0;
          end
        end
        LOAD: begin
          if (w_takt_rise) begin
            if (r_load_cnt == LW'(LOAD_EDGES - 1)) begin
              r_state    <= RUN;
              r_osc_load <= 1'b0;
              r_wr_ready <= 1'b1;
            end else begin
              r_load_cnt <= r_load_cnt + LW'(1);
            end
          end
        end
        RUN: begin
          // a command on the same cycle as a takt rise swallows that rise
          if (w_stop) begin
            r_state    <= IDLE;
            r_osc_load <= 1'b1;
            r_busy     <= 1'b0;
          end else if (w_start) begin
            r_state    <= LOAD;
            r_edge_cnt <= '0;
            r_load_cnt <= '0;
            r_osc_load <= 1'b1;
            r_wr_ready <= 1'b0;
          end else if (w_takt_rise) begin
            r_edge_cnt <= w_cnt_nxt;
            if ((w_burst != '0) && (w_cnt_nxt == w_burst)) begin
              r_state    <= IDLE;
              r_osc_load <= 1'b1;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
            end
          end
        end
        default: begin
          r_state    <= IDLE;
          r_osc_load <= 1'b1;
          r_busy     <= 1'b0;
          r_wr_ready <= 1'b1;
        end
      endcase
    end
  end

  assign osc_load = r_osc_load;
  assign busy     = r_busy;
  assign done     = r_done;
  assign edge_cnt = r_edge_cnt;

endmodule
`default_nettype wire

// File: tb/tb_qosc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_qosc_seq_ctrl : vector table, random traffic vs reference model, async reset
// Revision         : 1.0
// ============================================================================
module tb_qosc_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        takt = 1'b0;
  logic        osc_load, busy, done;
  logic [7:0]  re_coeff, im_coeff, power, accu_re_init, accu_im_init;
  logic [15:0] edge_cnt;

  qosc_seq_ctrl_if bus();

  qosc_seq_ctrl #(.LOAD_EDGES(2), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .takt         (takt),
    .host         (bus),
    .osc_load     (osc_load),
    .re_coeff     (re_coeff),
    .im_coeff     (im_coeff),
    .power        (power),
    .accu_re_init (accu_re_init),
    .accu_im_init (accu_im_init),
    .busy         (busy),
    .done         (done),
    .edge_cnt     (edge_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 = idle, 1 = loading, 2 = running
  int m_mode, m_sb, m_ab, m_cnt, m_lcnt;
  int m_sh[5];
  int m_act[5];
  bit m_done, m_tq;

  task automatic model_reset();
    m_sh   = '{'h7D, 'h1B, 'h40, 'h20, 'h00};
    m_act  = '{'h7D, 'h1B, 'h40, 'h20, 'h00};
    m_sb   = 0; m_ab = 0; m_cnt = 0; m_lcnt = 0;
    m_mode = 0; m_done = 0; m_tq = 0;
  endtask

  task automatic model_step(input bit t, input bit v, input int a, input int d);
    bit rise, acc, start, stop;
    rise   = t && !m_tq;
    m_tq   = t;
    acc    = v && (m_mode != 1);
    m_done = 0;
    if (acc && a < 5) m_sh[a] = d;
    if (acc && a == 5) m_sb = (m_sb & 'hFF00) | d;
    if (acc && a == 6) m_sb = (m_sb & 'h00FF) | (d << 8);
    stop  = acc && a == 7 && d[1];
    start = acc && a == 7 && d[0] && !d[1];
    if (start && m_mode != 1) begin
      m_act = m_sh; m_ab = m_sb; m_cnt = 0; m_lcnt = 0; m_mode = 1;
    end else if (stop) begin
      m_mode = 0;
    end else if (m_mode == 1 && rise) begin
      m_lcnt++;
      if (m_lcnt == 2) m_mode = 2;
    end else if (m_mode == 2 && rise) begin
      m_cnt = (m_cnt + 1) % 65536;
      if (m_ab != 0 && m_cnt == m_ab) begin
        m_mode = 0; m_done = 1;
      end
    end
  endtask

  task automatic model_check();
    chk("ctl{load,busy,done,ready}", {60'd0, osc_load, busy, done, bus.wr_ready},
        {60'd0, m_mode != 2, m_mode != 0, m_done, m_mode != 1});
    chk("edge_cnt", {48'd0, edge_cnt}, 64'(m_cnt));
    chk("cfg", {24'd0, re_coeff, im_coeff, power, accu_re_init, accu_im_init},
        {24'd0, 8'(m_act[0]), 8'(m_act[1]), 8'(m_act[2]), 8'(m_act[3]), 8'(m_act[4])});
  endtask

  // Drive one cycle's inputs at a negedge, then compare after the following posedge
  task automatic cyc(input bit t, input bit v, input int a, input int d);
    takt         = t;
    bus.wr_valid = v;
    bus.wr_addr  = 3'(a);
    bus.wr_data  = 8'(d);
    model_step(t, v, a, d);
    @(negedge clk);
    model_check();
  endtask

  task automatic chk_reset_values(input string nm);
    chk({nm, "_ctl"}, {60'd0, osc_load, busy, done, bus.wr_ready}, 64'b1001);
    chk({nm, "_cnt"}, {48'd0, edge_cnt}, 64'd0);
    chk({nm, "_cfg"}, {24'd0, re_coeff, im_coeff, power, accu_re_init, accu_im_init},
        64'h7D1B402000);
  endtask

  typedef struct {
    bit        t;
    bit        v;
    bit [2:0]  a;
    bit [7:0]  d;
    bit [3:0]  ctl;  // {osc_load, busy, done, wr_ready}
    bit [15:0] cnt;
    bit [7:0]  re;
  } vec_t;

  function automatic vec_t mk(bit t, bit v, bit [2:0] a, bit [7:0] d,
                              bit [3:0] ctl, bit [15:0] cnt, bit [7:0] re);
    vec_t r;
    r.t = t; r.v = v; r.a = a; r.d = d; r.ctl = ctl; r.cnt = cnt; r.re = re;
    return r;
  endfunction

  vec_t tbl[$];

  initial begin
    int ndone;
    int k;
    bit t;
    bit reached;

    // rows: takt, valid, addr, data -> expected state after the next edge
    tbl.push_back(mk(0, 1, 0, 8'h55, 4'b1001, 0, 8'h7D));
    tbl.push_back(mk(0, 1, 1, 8'h10, 4'b1001, 0, 8'h7D));
    tbl.push_back(mk(0, 1, 7, 8'h01, 4'b1100, 0, 8'h55));
    tbl.push_back(mk(1, 0, 0, 8'h00, 4'b1100, 0, 8'h55));
    tbl.push_back(mk(0, 0, 0, 8'h00, 4'b1100, 0, 8'h55));
    tbl.push_back(mk(1, 0, 0, 8'h00, 4'b0101, 0, 8'h55));
    tbl.push_back(mk(0, 0, 0, 8'h00, 4'b0101, 0, 8'h55));
    tbl.push_back(mk(1, 0, 0, 8'h00, 4'b0101, 1, 8'h55));
    tbl.push_back(mk(1, 0, 0, 8'h00, 4'b0101, 1, 8'h55));
    tbl.push_back(mk(0, 0, 0, 8'h00, 4'b0101, 1, 8'h55));
    tbl.push_back(mk(1, 1, 0, 8'h22, 4'b0101, 2, 8'h55));
    tbl.push_back(mk(0, 1, 7, 8'h03, 4'b1001, 2, 8'h55));
    tbl.push_back(mk(1, 0, 0, 8'h00, 4'b1001, 2, 8'h55));
    tbl.push_back(mk(0, 1, 5, 8'h03, 4'b1001, 2, 8'h55));
    tbl.push_back(mk(0, 1, 7, 8'h01, 4'b1100, 0, 8'h22));
    tbl.push_back(mk(1, 1, 0, 8'h99, 4'b1100, 0, 8'h22));
    tbl.push_back(mk(0, 1, 0, 8'h99, 4'b1100, 0, 8'h22));
    tbl.push_back(mk(1, 1, 0, 8'h99, 4'b0101, 0, 8'h22));
    tbl.push_back(mk(0, 1, 0, 8'h99, 4'b0101, 0, 8'h22));
    tbl.push_back(mk(1, 0, 0, 8'h00, 4'b0101, 1, 8'h22));
    tbl.push_back(mk(0, 0, 0, 8'h00, 4'b0101, 1, 8'h22));
    tbl.push_back(mk(1, 0, 0, 8'h00, 4'b0101, 2, 8'h22));
    tbl.push_back(mk(0, 0, 0, 8'h00, 4'b0101, 2, 8'h22));
    tbl.push_back(mk(1, 0, 0, 8'h00, 4'b1011, 3, 8'h22));
    tbl.push_back(mk(0, 0, 0, 8'h00, 4'b1001, 3, 8'h22));
    tbl.push_back(mk(0, 1, 7, 8'h03, 4'b1001, 3, 8'h22));
    tbl.push_back(mk(0, 1, 7, 8'h01, 4'b1100, 0, 8'h99));
    tbl.push_back(mk(1, 0, 0, 8'h00, 4'b1100, 0, 8'h99));
    tbl.push_back(mk(0, 0, 0, 8'h00, 4'b1100, 0, 8'h99));
    tbl.push_back(mk(1, 0, 0, 8'h00, 4'b0101, 0, 8'h99));
    tbl.push_back(mk(0, 1, 0, 8'h44, 4'b0101, 0, 8'h99));
    tbl.push_back(mk(1, 1, 7, 8'h01, 4'b1100, 0, 8'h44));

    bus.wr_valid = 1'b0;
    bus.wr_addr  = 3'd0;
    bus.wr_data  = 8'd0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_values("reset");
    rst_n = 1'b1;

    // idle with takt toggling every 8 clk
    for (int i = 0; i < 32; i++) cyc(((i / 8) % 2) == 1, 0, 0, 0);

    foreach (tbl[i]) begin
      cyc(tbl[i].t, tbl[i].v, tbl[i].a, tbl[i].d);
      chk($sformatf("tbl%0d_ctl", i), {60'd0, osc_load, busy, done, bus.wr_ready}, 64'(tbl[i].ctl));
      chk($sformatf("tbl%0d_cnt", i), {48'd0, edge_cnt}, 64'(tbl[i].cnt));
      chk($sformatf("tbl%0d_re", i), {56'd0, re_coeff}, 64'(tbl[i].re));
    end

    // random traffic against the model
    t = takt;
    for (int i = 0; i < 3000; i++) begin
      int a, d;
      bit v;
      if ($urandom_range(0, 2) == 0) t = ~t;
      v = ($urandom_range(0, 3) == 0);
      a = $urandom_range(0, 7);
      if (a == 5)      d = $urandom_range(0, 6);
      else if (a == 6) d = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : 0;
      else if (a == 7) d = $urandom_range(0, 3);
      else             d = $urandom_range(0, 255);
      cyc(t, v, a, d);
    end

    // clean restart, then a five-edge burst
    bus.wr_valid = 1'b0;
    takt  = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 1, 5, 5);
    cyc(0, 1, 6, 0);
    cyc(0, 1, 7, 1);
    ndone = 0;
    for (int i = 0; i < 80; i++) begin
      cyc(((i / 4) % 2) == 1, 0, 0, 0);
      if (done) ndone++;
    end
    chk("burst_done_pulses", 64'(ndone), 64'd1);
    chk("burst_cnt_held", {48'd0, edge_cnt}, 64'd5);
    chk("burst_idle{busy,load}", {62'd0, busy, osc_load}, 64'b01);

    // restart and hit reset asynchronously in the middle of RUN
    cyc(0, 1, 0, 8'hA5);
    cyc(0, 1, 7, 1);
    reached = 0;
    k = 0;
    while (!reached && k < 100) begin
      cyc(((k / 3) % 2) == 1, 0, 0, 0);
      if (m_mode == 2 && m_cnt == 2) reached = 1;
      k++;
    end
    chk("reach_run_midpoint", 64'(reached), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_values("async_reset");
    model_reset();
    takt = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/qosc_seq_ctrl.md
Name: qosc_seq_ctrl

Overview:
- Configuration and run sequencer for the quadrature oscillator: replaces hard-wired coefficient/init constants with writable shadow registers and generates the oscillator's load signal.
- Lives in the system clk domain, between the pin-level host interface and the oscillator.
- Takes the synchronized reference-clock level (takt), counts its rising edges, and sequences IDLE -> LOAD -> RUN with optional finite-length bursts.

Parameters:
- LOAD_EDGES, 2, number of takt rising edges osc_load is held high in LOAD (>=1).
- CNT_W, 16, width of burst length and takt edge counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- takt  in  1  synchronized reference clock level (already in clk domain).
- wr_valid  in  1  host write request.
- wr_ready  out  1  write accepted when wr_valid & wr_ready at clk edge.
- wr_addr  in  3  register address.
- wr_data  in  8  write data.
- osc_load  out  1  oscillator preload (1 = hold at init values).
- re_coeff, im_coeff, power, accu_re_init, accu_im_init  out  8 each  active oscillator config.
- busy  out  1  high in LOAD or RUN.
- done  out  1  one-clk pulse when a finite burst completes.
- edge_cnt  out  CNT_W  takt rising edges counted in current RUN.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - State IDLE, osc_load=1, busy=0, done=0, edge_cnt=0, wr_ready=1.
  - Shadow and active registers: re 0x7D, im 0x1B, power 0x40, accu_re_init 0x20, accu_im_init 0x00, burst_len 0.
- takt_rise = takt & ~takt_q, with takt_q a clk register (reset 0).
- Register map (writes go to shadow registers):
  - 0 re_coeff, 1 im_coeff, 2 power, 3 accu_re_init, 4 accu_im_init.
  - 5 burst_len[7:0], 6 burst_len[15:8] (upper bits ignored if CNT_W<16).
  - 7 command: bit0 START, bit1 STOP, other bits ignored.
- Active config outputs change only on the START copy; shadow writes never disturb a running oscillator.
- wr_ready = 0 in LOAD, 1 otherwise. Writes presented during LOAD stall and are not dropped.
- IDLE:
  - osc_load=1, edge_cnt held.
  - Accepted START (STOP=0): in the same edge, copy all shadow registers to active, clear edge_cnt and load counter, go to LOAD.
- LOAD:
  - osc_load=1, busy=1.
  - Count takt_rise. On the LOAD_EDGES-th rise, go to RUN; osc_load=0 from the next cycle.
- RUN:
  - osc_load=0, busy=1. edge_cnt increments on each takt_rise, wrapping at 2^CNT_W.
  - If burst_len != 0 and a takt_rise makes edge_cnt == burst_len: next state IDLE, done=1 for exactly one clk, osc_load=1.
  - burst_len == 0: run until stopped.
- Command handling:
  - STOP accepted in RUN or IDLE: go/stay IDLE, no done pulse.
  - START and STOP both set: STOP wins.
  - START accepted in RUN: restart. Shadow copied to active, edge_cnt cleared, go to LOAD.
- burst_len comparison uses the active copy, latched at START. Shadow writes to 5/6 during RUN affect only the next START.
- takt_rise on the same cycle as a command: the command takes priority and that edge is not counted.
- Reset mid-operation: immediate return to reset values, including active config.

Decomposition:
- Shared package qosc_pkg holds:
  - Register address constants (ADDR_RE..ADDR_CMD).
  - Command bit positions.
  - Reset-default localparams (0x7D, 0x1B, 0x40, 0x20, 0x00).
  - State enum {IDLE, LOAD, RUN}.
- One natural sub-module, qosc_regfile: shadow/active register bank with the write handshake and copy strobe. The FSM and counters stay in qosc_seq_ctrl.

Test Plan:
- Reset then idle, takt toggling every 8 clk -> osc_load=1, outputs 7D/1B/40/20/00, busy=0, edge_cnt=0.
- Write re=0x55, im=0x10, then cmd=0x01 -> active outputs change on the accept edge. osc_load falls after 2nd takt rise. edge_cnt counts 1,2,3…
- burst_len=5, START -> exactly 5 takt rises in RUN, then a single-cycle done, osc_load=1, busy=0, edge_cnt=5 held.
- During RUN write re=0x22 -> re_coeff output unchanged. Then START -> re_coeff=0x22, edge_cnt=0, state LOAD.
- Write cmd=0x03 in RUN -> IDLE, no done pulse. Write attempted during LOAD -> wr_ready=0 until RUN, then the write completes.
- Assert rst_n=0 mid-RUN asynchronously -> all outputs return to reset values without waiting for a clk edge.
